// File: rtl/galois_pow_inv_7.sv
// Computes base^E mod p by right-to-left square-and-multiply over two parallel modular multipliers.
// Optional macro GALOIS_POW_INV_7_RUNTIME_EXP_EN adds a runtime `exponent` port in place of EXPONENT.

module galois_mult #(
  parameter int                N_BITS             = 254,
  parameter string             GALOIS_MULT_METHOD = "peasant",
  parameter logic [N_BITS-1:0] MODULUS            = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic [N_BITS-1:0] product,
  output logic              done
);
  // "peasant" retires two multiplier bits per cycle; "peasant_serial" retires one.
  localparam int BPC   = (GALOIS_MULT_METHOD == "peasant_serial") ? 1 : 2;
  localparam int STEPS = (N_BITS + BPC - 1) / BPC;
  localparam int SW    = STEPS * BPC;
  localparam int CW    = $clog2(STEPS + 1);

  logic [N_BITS-1:0] a_q;
  logic [N_BITS-1:0] acc_next;
  logic [SW-1:0]     b_sh;
  logic [CW-1:0]     cnt;

  // One MSB-first peasant step: acc = 2*acc + bit*y, kept below MODULUS.
  function automatic logic [N_BITS-1:0] dbl_add(input logic [N_BITS-1:0] x,
                                                input logic [N_BITS-1:0] y,
                                                input logic              bt);
    logic [N_BITS:0] t;
    t = {x, 1'b0};
    if (t >= {1'b0, MODULUS}) t = t - {1'b0, MODULUS};
    if (bt) t = t + {1'b0, y};
    if (t >= {1'b0, MODULUS}) t = t - {1'b0, MODULUS};
    return t[N_BITS-1:0];
  endfunction

  // NOTE: every variable assigned here gets a value first, so no latch is inferred.
  always_comb begin
    acc_next = product;
    for (int k = 0; k < BPC; k++) acc_next = dbl_add(acc_next, a_q, b_sh[SW-1-k]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= a;
      b_sh    <= SW'(b);
      product <= '0;
      cnt     <= '0;
    end else if (cnt != CW'(STEPS)) begin
      product <= acc_next;
      b_sh    <= b_sh << BPC;
      cnt     <= cnt + CW'(1);
    end
  end

  assign done = (cnt == CW'(STEPS));
endmodule

module galois_pow_inv_7 #(
  parameter int                N_BITS             = 254,
  parameter string             GALOIS_MULT_METHOD = "peasant",
  parameter logic [N_BITS-1:0] EXPONENT           = N_BITS'(7),
  parameter logic [N_BITS-1:0] MODULUS            = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_BITS-1:0] base,
`ifdef GALOIS_POW_INV_7_RUNTIME_EXP_EN
  input  logic [N_BITS-1:0] exponent,
`endif
  output logic [N_BITS-1:0] result,
  output logic              done
);
  localparam int IW = $clog2(N_BITS);

  typedef enum logic [2:0] {IDLE, LOAD, MULT_A, MULT_B, MULT_C, FINISH} state_t;

  state_t            state;
  logic [N_BITS-1:0] acc, sq;
  logic [N_BITS-1:0] mult_1_product, mult_2_product;
  logic [IW-1:0]     idx;
  logic              mult_rst, mult_1_done, mult_2_done;
  logic              e_bit, e_zero;

`ifdef GALOIS_POW_INV_7_RUNTIME_EXP_EN
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BITS - 1);
  logic [N_BITS-1:0] exp_q;
  assign e_bit  = exp_q[idx];
  assign e_zero = (exponent == '0);
`else
  function automatic int msb_index(input logic [N_BITS-1:0] e);
    int m;
    m = 0;
    for (int k = 0; k < N_BITS; k++) if (e[k]) m = k;
    return m;
  endfunction
  // Leading zeros of a fixed exponent are never iterated.
  localparam logic [IW-1:0] LAST_IDX = IW'(msb_index(EXPONENT));
  assign e_bit  = EXPONENT[idx];
  assign e_zero = (EXPONENT == '0);
`endif

  galois_mult #(.N_BITS(N_BITS), .GALOIS_MULT_METHOD(GALOIS_MULT_METHOD), .MODULUS(MODULUS)) mult_1 (
    .clk(clk), .rst(mult_rst), .a(acc), .b(sq), .product(mult_1_product), .done(mult_1_done)
  );

  galois_mult #(.N_BITS(N_BITS), .GALOIS_MULT_METHOD(GALOIS_MULT_METHOD), .MODULUS(MODULUS)) mult_2 (
    .clk(clk), .rst(mult_rst), .a(sq), .b(sq), .product(mult_2_product), .done(mult_2_done)
  );

  // Multipliers capture (acc,sq) on the edge leaving MULT_A, while mult_rst is still high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      result   <= '0;
      acc      <= '0;
      sq       <= '0;
      idx      <= '0;
      mult_rst <= 1'b1;
`ifdef GALOIS_POW_INV_7_RUNTIME_EXP_EN
      exp_q    <= EXPONENT;
`endif
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          mult_rst <= 1'b1;
          if (en) state <= LOAD;
        end
        LOAD: begin
          acc      <= N_BITS'(1);
          sq       <= base;
          idx      <= '0;
          mult_rst <= 1'b1;
`ifdef GALOIS_POW_INV_7_RUNTIME_EXP_EN
          exp_q    <= exponent;
`endif
          state    <= e_zero ? FINISH : MULT_A;
        end
        MULT_A: begin
          mult_rst <= 1'b0;
          state    <= MULT_B;
        end
        MULT_B: begin
          if (mult_1_done && mult_2_done) begin
            mult_rst <= 1'b1;
            state    <= MULT_C;
          end
        end
        MULT_C: begin
          if (e_bit) acc <= mult_1_product;
          sq       <= mult_2_product;
          mult_rst <= 1'b1;
          if (idx == LAST_IDX) begin
            state <= FINISH;
          end else begin
            idx   <= idx + IW'(1);
            state <= MULT_A;
          end
        end
        FINISH: begin
          result <= acc;
          done   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_galois_pow_inv_7.sv
// Randomized self-checking bench for galois_pow_inv_7 against a plain modular-arithmetic model.
// Five instances: EXPONENT 7, 0, 45 and two 7th-root instances run in parallel.

module tb_galois_pow_inv_7;
  localparam int N  = 254;
  localparam int TW = N + 8;
  localparam int NI = 5;
  localparam logic [N-1:0] P = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  // Default "peasant" multiplier needs ceil(N/2) cycles per product.
  localparam int MULT_L = (N + 1) / 2;

  // 7^-1 mod m: the one k in 0..6 with 7 | (1 + k*m) gives (1 + k*m)/7.
  function automatic logic [N-1:0] inv7_mod(input logic [N-1:0] m);
    logic [TW-1:0] t;
    logic [N-1:0]  r;
    r = '0;
    for (int k = 0; k < 7; k++) begin
      t = TW'(1) + TW'(k) * {8'b0, m};
      if (t % TW'(7) == '0 && r == '0) r = N'(t / TW'(7));
    end
    return r;
  endfunction

  localparam logic [N-1:0] INV7 = inv7_mod(P - N'(1));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst    [NI];
  logic          en     [NI];
  logic [N-1:0]  base   [NI];
  logic [N-1:0]  result [NI];
  logic          done   [NI];
`ifdef GALOIS_POW_INV_7_RUNTIME_EXP_EN
  logic [N-1:0]  exponent [NI];
`endif

  int checks = 0;
  int errors = 0;

  galois_pow_inv_7 #(.N_BITS(N), .EXPONENT(N'(7))) u_e7 (
    .clk(clk), .rst(rst[0]), .en(en[0]), .base(base[0]),
`ifdef GALOIS_POW_INV_7_RUNTIME_EXP_EN
    .exponent(exponent[0]),
`endif
    .result(result[0]), .done(done[0]));

  galois_pow_inv_7 #(.N_BITS(N), .EXPONENT('0)) u_e0 (
    .clk(clk), .rst(rst[1]), .en(en[1]), .base(base[1]),
`ifdef GALOIS_POW_INV_7_RUNTIME_EXP_EN
    .exponent(exponent[1]),
`endif
    .result(result[1]), .done(done[1]));

  galois_pow_inv_7 #(.N_BITS(N), .EXPONENT(N'(45))) u_e45 (
    .clk(clk), .rst(rst[2]), .en(en[2]), .base(base[2]),
`ifdef GALOIS_POW_INV_7_RUNTIME_EXP_EN
    .exponent(exponent[2]),
`endif
    .result(result[2]), .done(done[2]));

  galois_pow_inv_7 #(.N_BITS(N), .EXPONENT(INV7)) u_inv_a (
    .clk(clk), .rst(rst[3]), .en(en[3]), .base(base[3]),
`ifdef GALOIS_POW_INV_7_RUNTIME_EXP_EN
    .exponent(exponent[3]),
`endif
    .result(result[3]), .done(done[3]));

  galois_pow_inv_7 #(.N_BITS(N), .EXPONENT(INV7)) u_inv_b (
    .clk(clk), .rst(rst[4]), .en(en[4]), .base(base[4]),
`ifdef GALOIS_POW_INV_7_RUNTIME_EXP_EN
    .exponent(exponent[4]),
`endif
    .result(result[4]), .done(done[4]));

  function automatic logic [N-1:0] mod_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] w;
    w = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    w = w % {{N{1'b0}}, P};
    return w[N-1:0];
  endfunction

  // b multiplied into 1 exactly e times.
  function automatic logic [N-1:0] pow_small(input logic [N-1:0] b, input int e);
    logic [N-1:0] r;
    r = N'(1);
    for (int k = 0; k < e; k++) r = mod_mul(r, b);
    return r;
  endfunction

  function automatic logic [N-1:0] rand_elem();
    logic [255:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w = {w[223:0], 32'($urandom)};
    return N'(w % {2'b0, P});
  endfunction

  function automatic int msb_idx(input logic [N-1:0] e);
    int m;
    m = 0;
    for (int k = 0; k < N; k++) if (e[k]) m = k;
    return m;
  endfunction

  function automatic int lat(input int iters);
    return 2 + iters * (3 + MULT_L);
  endfunction

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_rst(input int k);
    rst[k] = 1'b1;
    @(posedge clk); #1;
    rst[k] = 1'b0;
    check("rst_done", N'(done[k]), '0);
    check("rst_result", result[k], '0);
  endtask

  // Starts one operation on instance k, scrambles inputs after LOAD, checks latency, result and stickiness.
  task automatic run_op(input int k, input logic [N-1:0] b, input logic [N-1:0] want,
                        input int want_lat, input int hold, input string tag);
    int cyc;
    int good;
    bit seen;
    base[k] = b;
    en[k]   = 1'b1;
    @(posedge clk); #1;
    en[k] = 1'b0;
    cyc   = 0;
    seen  = 1'b0;
    while (!seen && cyc < want_lat + 32) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        base[k] = rand_elem();
        en[k]   = 1'b1;
`ifdef GALOIS_POW_INV_7_RUNTIME_EXP_EN
        exponent[k] = exponent[k] + N'(5);
`endif
      end else begin
        en[k] = 1'b0;
      end
      seen = done[k];
    end
    en[k] = 1'b0;
    check({tag, "_latency"}, N'(cyc), N'(want_lat));
    check({tag, "_result"}, result[k], want);
    if (hold > 0) begin
      good = 0;
      repeat (hold) begin
        @(posedge clk); #1;
        if (done[k] && result[k] == want) good++;
      end
      check({tag, "_sticky"}, N'(good), N'(hold));
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k]  = 1'b1;
      en[k]   = 1'b0;
      base[k] = '0;
`ifdef GALOIS_POW_INV_7_RUNTIME_EXP_EN
      exponent[k] = '0;
`endif
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    for (int k = 0; k < NI; k++) begin
      check("reset_done", N'(done[k]), '0);
      check("reset_result", result[k], '0);
    end

`ifdef GALOIS_POW_INV_7_RUNTIME_EXP_EN
    exponent[0] = N'(4);
    run_op(0, N'(3), N'(81), lat(N), 0, "rt_exp4");
    pulse_rst(0);
    exponent[0] = '0;
    run_op(0, N'(5), N'(1), 2, 3, "rt_exp0");
    pulse_rst(0);
`else
    fork
      run_op(3, pow_small(N'(5), 7), N'(5), lat(msb_idx(INV7) + 1), 2, "root_5");
      run_op(4, pow_small(P - N'(2), 7), P - N'(2), lat(msb_idx(INV7) + 1), 2, "root_pm2");
      begin
        logic [N-1:0] b;
        run_op(0, N'(2), N'(128), lat(3), 20, "e7_b2");
        pulse_rst(0);
        run_op(0, N'(3), N'(2187), lat(3), 0, "e7_b3");
        pulse_rst(0);
        run_op(0, '0, '0, lat(3), 0, "e7_b0");
        pulse_rst(0);
        run_op(0, N'(1), N'(1), lat(3), 0, "e7_b1");
        pulse_rst(0);

        // Abort inside the second MULT_B, then the very next en must run cleanly.
        base[0] = N'(2);
        en[0]   = 1'b1;
        @(posedge clk); #1;
        en[0] = 1'b0;
        repeat (MULT_L + 10) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        check("abort_done", N'(done[0]), '0);
        check("abort_result", result[0], '0);
        run_op(0, N'(3), N'(2187), lat(3), 0, "abort_b3");
        pulse_rst(0);

        for (int r = 0; r < 4; r++) begin
          b = rand_elem();
          run_op(0, b, pow_small(b, 7), lat(3), 0, "e7_rand");
          pulse_rst(0);
        end

        run_op(1, N'(5), N'(1), 2, 3, "e0_b5");
        pulse_rst(1);
        b = rand_elem();
        run_op(1, b, N'(1), 2, 0, "e0_rand");
        pulse_rst(1);

        run_op(2, N'(2), pow_small(N'(2), 45), lat(6), 0, "e45_b2");
        pulse_rst(2);
        for (int r = 0; r < 3; r++) begin
          b = rand_elem();
          run_op(2, b, pow_small(b, 45), lat(6), 0, "e45_rand");
          pulse_rst(2);
        end
      end
    join
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
